// File: rtl/centroid_overlay.sv
// centroid_overlay: draws a fixed-colour square outline marker on a live RGB stream, centred on the
// per-frame centroid produced upstream. The marker position and enable are latched once per frame
// on the vsync falling edge. Video timing and pixels pass through a 2-stage pipeline.
//
// Ports:
//   clk        pixel clock
//   rst        synchronous active-low reset (has priority over ce)
//   ce         clock enable; when low every register holds
//   en         marker enable, sampled at the frame latch
//   de         input data enable
//   vsync      input vertical sync, active high
//   hsync      input horizontal sync
//   pixel_in   input RGB pixel
//   xcent      centroid x, sampled at the frame latch
//   ycent      centroid y, sampled at the frame latch
//   de_out     de delayed 2 cycles
//   vsync_out  vsync delayed 2 cycles
//   hsync_out  hsync delayed 2 cycles
//   pixel_out  pixel_in delayed 2 cycles, replaced by COLOR on marker pixels
module centroid_overlay #(
  parameter int unsigned IMG_H = 720,
  parameter int unsigned IMG_W = 1280,
  parameter int unsigned HALF  = 8,
  parameter int unsigned THICK = 2,
  parameter logic [23:0] COLOR = 24'hFF0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        en,
  input  logic        de,
  input  logic        vsync,
  input  logic        hsync,
  input  logic [23:0] pixel_in,
  input  logic [10:0] xcent,
  input  logic [9:0]  ycent,
  output logic        de_out,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic [23:0] pixel_out
);

  localparam logic [10:0] XLast = 11'(IMG_W - 1);
  localparam logic [9:0]  YLast = 10'(IMG_H - 1);
  localparam logic [11:0] Half  = 12'(HALF);
  localparam logic [11:0] Inner = 12'(HALF - THICK);

  // Raster position of the pixel currently on the input.
  logic [10:0] x_pos_q, x_pos_d;
  logic [9:0]  y_pos_q, y_pos_d;
  logic        prev_vsync_q;

  // Per-frame latched marker parameters.
  logic [10:0] xc_q;
  logic [9:0]  yc_q;
  logic        mk_en_q;

  // Stage 1.
  logic [11:0] dx_q, dy_q;
  logic        de_s1_q, hs_s1_q, vs_s1_q;
  logic [23:0] px_s1_q;

  logic        frame_latch;
  logic [11:0] diff_x, diff_y, abs_x, abs_y;
  logic        marker_on;

  assign frame_latch = prev_vsync_q & ~vsync;

  // Differences are taken 12 bits wide so the sign bit never aliases a large coordinate;
  // off-raster parts of the box are thus simply never matched by any counter value.
  always_comb begin
    diff_x = {1'b0, x_pos_q} - {1'b0, xc_q};
    diff_y = {2'b00, y_pos_q} - {2'b00, yc_q};
    abs_x  = diff_x[11] ? (12'd0 - diff_x) : diff_x;
    abs_y  = diff_y[11] ? (12'd0 - diff_y) : diff_y;
  end

  always_comb begin
    x_pos_d = x_pos_q;
    y_pos_d = y_pos_q;
    if (vsync) begin
      x_pos_d = '0;
      y_pos_d = '0;
    end else if (de) begin
      if (x_pos_q == XLast) begin
        x_pos_d = '0;
        y_pos_d = (y_pos_q == YLast) ? '0 : y_pos_q + 10'd1;
      end else begin
        x_pos_d = x_pos_q + 11'd1;
      end
    end
  end

  // Inside the outer square but outside the inner one gives the outline ring.
  assign marker_on = mk_en_q & de_s1_q & (dx_q <= Half) & (dy_q <= Half) &
                     ((dx_q > Inner) | (dy_q > Inner));

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_pos_q      <= '0;
      y_pos_q      <= '0;
      prev_vsync_q <= 1'b0;
      xc_q         <= '0;
      yc_q         <= '0;
      mk_en_q      <= 1'b0;
      dx_q         <= '0;
      dy_q         <= '0;
      de_s1_q      <= 1'b0;
      hs_s1_q      <= 1'b0;
      vs_s1_q      <= 1'b0;
      px_s1_q      <= '0;
      de_out       <= 1'b0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      pixel_out    <= '0;
    end else if (ce) begin
      x_pos_q      <= x_pos_d;
      y_pos_q      <= y_pos_d;
      prev_vsync_q <= vsync;
      if (frame_latch) begin
        xc_q    <= xcent;
        yc_q    <= ycent;
        mk_en_q <= en;
      end
      dx_q      <= abs_x;
      dy_q      <= abs_y;
      de_s1_q   <= de;
      hs_s1_q   <= hsync;
      vs_s1_q   <= vsync;
      px_s1_q   <= pixel_in;
      de_out    <= de_s1_q;
      hsync_out <= hs_s1_q;
      vsync_out <= vs_s1_q;
      pixel_out <= marker_on ? COLOR : px_s1_q;
    end
  end

endmodule

// File: tb/tb_centroid_overlay.sv
module tb_centroid_overlay;

  localparam int W = 16;
  localparam int H = 12;
  localparam int HALF_T = 2;
  localparam int THICK_T = 1;
  localparam logic [23:0] COL = 24'hFF0000;
  localparam logic [23:0] BLANK_PX = 24'h0000FF;

  logic        clk = 1'b0;
  logic        rst, ce, en, de, vsync, hsync;
  logic [23:0] pixel_in;
  logic [10:0] xcent;
  logic [9:0]  ycent;
  logic        de_out, vsync_out, hsync_out;
  logic [23:0] pixel_out;

  centroid_overlay #(
    .IMG_H(H), .IMG_W(W), .HALF(HALF_T), .THICK(THICK_T), .COLOR(COL)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .en(en), .de(de), .vsync(vsync), .hsync(hsync),
    .pixel_in(pixel_in), .xcent(xcent), .ycent(ycent), .de_out(de_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .pixel_out(pixel_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output-side monitor: only edges taken with ce=1 produce a new output sample.
  bit ce_e = 1'b0;
  always @(posedge clk) ce_e <= ce;

  int mark_cnt, stray, ox, oy;
  bit [W-1:0] marked [H];

  always @(negedge clk) begin
    if (ce_e) begin
      if (vsync_out) begin
        ox = 0;
        oy = 0;
      end else if (de_out) begin
        if (pixel_out == COL) begin
          mark_cnt++;
          if (ox < W && oy < H) marked[oy][ox] = 1'b1;
        end else if (pixel_out != 24'h0) begin
          stray++;
        end
        if (ox == W - 1) begin
          ox = 0;
          oy = (oy == H - 1) ? 0 : oy + 1;
        end else begin
          ox++;
        end
      end else if (pixel_out == COL) begin
        stray++;
      end
    end
  end

  function automatic bit exp_mark(input int x, input int y, input int xc, input int yc,
                                  input bit e);
    int ax, ay, m;
    ax = (x > xc) ? x - xc : xc - x;
    ay = (y > yc) ? y - yc : yc - y;
    m  = (ax > ay) ? ax : ay;
    return e && (m <= HALF_T) && (m > HALF_T - THICK_T);
  endfunction

  typedef struct {
    int xc;
    int yc;
    bit en;
    bit gap;      // insert a ce=0,0 pause mid-line
    int rst_row;  // row at whose start rst pulses low, -1 for none
    int cnt;      // expected marked pixels this frame
    int px;
    int py;
    bit pexp;     // expected marking of probe pixel (px,py)
  } vec_t;

  vec_t vecs[14];

  task automatic run_frame(input vec_t v, input int idx);
    int diffs;
    xcent = 11'(v.xc);
    ycent = 10'(v.yc);
    en = v.en;
    de = 1'b0;
    hsync = 1'b0;
    pixel_in = BLANK_PX;
    mark_cnt = 0;
    stray = 0;
    for (int y = 0; y < H; y++) marked[y] = '0;
    vsync = 1'b1;
    step();
    step();
    vsync = 1'b0;
    step();
    // Anything after the latch edge must be ignored until the next frame.
    xcent = ~xcent;
    ycent = ~ycent;
    en = ~en;
    for (int y = 0; y < H; y++) begin
      hsync = 1'b1;
      de = 1'b0;
      pixel_in = BLANK_PX;
      step();
      step();
      hsync = 1'b0;
      step();
      if (y == v.rst_row) begin
        rst = 1'b0;
        step();
        chk($sformatf("v%0d rst_flush", idx), {de_out, hsync_out, vsync_out, pixel_out}, 64'h0);
        rst = 1'b1;
      end
      for (int x = 0; x < W; x++) begin
        if (v.gap && y == 2 && x == 4) begin
          ce = 1'b0;
          de = 1'b1;
          pixel_in = 24'hABCDEF;
          step();
          step();
          ce = 1'b1;
        end
        de = 1'b1;
        pixel_in = 24'h0;
        step();
      end
      de = 1'b0;
      pixel_in = BLANK_PX;
    end
    for (int i = 0; i < 4; i++) step();

    chk($sformatf("v%0d mark_count", idx), mark_cnt, v.cnt);
    chk($sformatf("v%0d stray_pixels", idx), stray, 0);
    chk($sformatf("v%0d probe(%0d,%0d)", idx, v.px, v.py), marked[v.py][v.px], v.pexp);
    if (v.rst_row < 0) begin
      diffs = 0;
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          if (marked[y][x] != exp_mark(x, y, v.xc, v.yc, v.en)) diffs++;
      chk($sformatf("v%0d bitmap_diffs", idx), diffs, 0);
    end
  endtask

  initial begin
    //          xc  yc en gap rst cnt px  py pexp
    vecs[0]  = '{5,  4, 1, 0, -1, 16, 5,  4, 0};
    vecs[1]  = '{5,  4, 1, 0, -1, 16, 3,  2, 1};
    vecs[2]  = '{9,  4, 1, 0, -1, 16, 11, 4, 1};
    vecs[3]  = '{9,  4, 0, 0, -1, 0,  9,  2, 0};
    vecs[4]  = '{0,  0, 1, 0, -1, 5,  2,  2, 1};
    vecs[5]  = '{0,  0, 1, 0, -1, 5,  15, 11, 0};
    vecs[6]  = '{15, 11, 1, 0, -1, 5, 13, 11, 1};
    vecs[7]  = '{20, 4, 1, 0, -1, 0,  15, 4, 0};
    vecs[8]  = '{17, 4, 1, 0, -1, 5,  15, 2, 1};
    vecs[9]  = '{8,  0, 1, 0, -1, 9,  6,  0, 1};
    vecs[10] = '{1,  6, 1, 0, -1, 11, 0,  6, 0};
    vecs[11] = '{5,  4, 1, 1, -1, 16, 3,  2, 1};
    vecs[12] = '{5,  4, 1, 0, 3,  5,  3,  2, 1};
    vecs[13] = '{5,  4, 1, 0, -1, 16, 7,  6, 1};

    rst = 1'b0;
    ce = 1'b1;
    en = 1'b0;
    de = 1'b1;
    vsync = 1'b0;
    hsync = 1'b1;
    pixel_in = 24'hFFFFFF;
    xcent = '0;
    ycent = '0;
    step();
    step();
    chk("reset_outputs", {de_out, hsync_out, vsync_out, pixel_out}, 64'h0);
    rst = 1'b1;
    de = 1'b0;
    hsync = 1'b0;
    pixel_in = 24'h0;
    step();
    step();
    step();

    // Latency of de/hsync/pixel.
    de = 1'b1;
    hsync = 1'b1;
    pixel_in = 24'h123456;
    step();
    chk("lat_de_at_n1", {de_out, hsync_out}, 64'h0);
    de = 1'b0;
    hsync = 1'b0;
    pixel_in = 24'h0;
    step();
    chk("lat_at_n2", {de_out, hsync_out, pixel_out}, {2'b11, 24'h123456});
    step();
    chk("lat_fall_n3", {de_out, hsync_out}, 64'h0);

    // Latency of vsync (en=0 so the latch leaves the marker off).
    vsync = 1'b1;
    step();
    chk("vs_at_n1", vsync_out, 1'b0);
    step();
    chk("vs_at_n2", vsync_out, 1'b1);
    vsync = 1'b0;
    step();
    chk("vs_hold_n3", vsync_out, 1'b1);
    step();
    chk("vs_fall_n4", vsync_out, 1'b0);

    // ce pattern 1,0,0,1: outputs freeze while ce is low.
    de = 1'b1;
    pixel_in = 24'hAAAAAA;
    step();
    pixel_in = 24'h555555;
    step();
    chk("ce_first", pixel_out, 24'hAAAAAA);
    ce = 1'b0;
    de = 1'b0;
    pixel_in = 24'h777777;
    step();
    chk("ce_hold1", {de_out, pixel_out}, {1'b1, 24'hAAAAAA});
    step();
    chk("ce_hold2", {de_out, pixel_out}, {1'b1, 24'hAAAAAA});
    ce = 1'b1;
    step();
    chk("ce_resume", pixel_out, 24'h555555);
    step();
    step();

    for (int i = 0; i < 14; i++) run_frame(vecs[i], i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
